div_arb: RTL and testbench

DIV_ARB -- requirements
Module: div_arb

---
 rtl/div_arb_if.sv | 37 +++
 rtl/div_arb.sv | 153 +++++++++++++++
 tb/tb_div_arb.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div_arb_if.sv
// Requester-side bus of div_arb: two operation request channels (valid/ready
// handshake, 8-bit dividend a, 5-bit divisor b) and two registered response
// channels (one-cycle valid pulse, quotient q, remainder r, divide-by-zero dz).
//   slave  : seen by the arbiter (takes requests, drives ready and responses)
//   master : seen by the requesters
interface div_arb_if;
  logic       req0_valid;
  logic       req1_valid;
  logic [7:0] req0_a;
  logic [7:0] req1_a;
  logic [4:0] req0_b;
  logic [4:0] req1_b;
  logic       req0_ready;
  logic       req1_ready;
  logic       resp0_valid;
  logic       resp1_valid;
  logic [7:0] resp0_q;
  logic [7:0] resp1_q;
  logic [4:0] resp0_r;
  logic [4:0] resp1_r;
  logic       resp0_dz;
  logic       resp1_dz;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b,
    output req0_ready, req1_ready,
    output resp0_valid, resp1_valid, resp0_q, resp1_q,
    output resp0_r, resp1_r, resp0_dz, resp1_dz
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp1_valid, resp0_q, resp1_q,
    input  resp0_r, resp1_r, resp0_dz, resp1_dz
  );
endinterface

// File: rtl/div_arb.sv
// Two-requester round-robin arbiter in front of a shared fixed-latency divider.
// Each requester may have up to MAX_OUT operations outstanding; results are
// routed back by a tag pipeline that tracks the divider latency.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   bus (slave)      requester handshakes and registered responses
//   div_in_valid/div_a/div_b   registered operands to the divider
//   div_q/div_r      divider results, valid DIV_LAT edges after the operands
//   div_out_valid    divider valid, not used for routing
//   number           transistor count of instantiated library cells
module div_arb #(
  parameter int unsigned DIV_LAT = 7,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  div_arb_if.slave    bus,
  output logic        div_in_valid,
  output logic [7:0]  div_a,
  output logic [4:0]  div_b,
  input  logic [7:0]  div_q,
  input  logic [4:0]  div_r,
  input  logic        div_out_valid,
  output logic [50:0] number
);

  typedef enum logic {PRI0, PRI1} pri_e;

  typedef struct packed {
    logic valid;
    logic id;
    logic dz;
  } tag_t;

  localparam logic [3:0] CAP = 4'(MAX_OUT);

  pri_e       ptr, ptr_next;
  logic [3:0] out_cnt0, out_cnt1;
  logic       elig0, elig1;
  logic       grant0, grant1;
  logic       ret0, ret1;
  tag_t       tag_in;
  tag_t       tag_pipe [DIV_LAT];
  tag_t       tail;
  logic       unused_div_out_valid;

  // Only inferred logic; no library cells are instantiated.
  assign number = '0;
  assign unused_div_out_valid = div_out_valid;

  assign elig0 = (out_cnt0 < CAP);
  assign elig1 = (out_cnt1 < CAP);

  always_comb begin
    grant0   = 1'b0;
    grant1   = 1'b0;
    ptr_next = ptr;
    if (rst_n) begin
      if (bus.req0_valid && elig0 &&
          (ptr == PRI0 || !(bus.req1_valid && elig1)))
        grant0 = 1'b1;
      else if (bus.req1_valid && elig1)
        grant1 = 1'b1;
    end
    if (grant0)
      ptr_next = PRI1;
    else if (grant1)
      ptr_next = PRI0;
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= PRI0;
    else        ptr <= ptr_next;
  end

  // The tag is registered together with the operands; the DIV_LAT-deep shift
  // behind it then lines the tail up with div_q/div_r one edge before capture.
  assign tail = tag_pipe[DIV_LAT-1];
  assign ret0 = tail.valid && !tail.id;
  assign ret1 = tail.valid &&  tail.id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_in_valid <= 1'b0;
      div_a        <= '0;
      div_b        <= '0;
      tag_in       <= '0;
      for (int unsigned i = 0; i < DIV_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      div_in_valid <= grant0 || grant1;
      if (grant0) begin
        div_a <= bus.req0_a;
        div_b <= bus.req0_b;
      end else if (grant1) begin
        div_a <= bus.req1_a;
        div_b <= bus.req1_b;
      end
      tag_in.valid <= grant0 || grant1;
      tag_in.id    <= grant1;
      tag_in.dz    <= grant1 ? (bus.req1_b == '0) : (bus.req0_b == '0);
      tag_pipe[0]  <= tag_in;
      for (int unsigned i = 1; i < DIV_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.resp0_valid <= 1'b0;
      bus.resp1_valid <= 1'b0;
      bus.resp0_q     <= '0;
      bus.resp1_q     <= '0;
      bus.resp0_r     <= '0;
      bus.resp1_r     <= '0;
      bus.resp0_dz    <= 1'b0;
      bus.resp1_dz    <= 1'b0;
    end else begin
      bus.resp0_valid <= ret0;
      bus.resp1_valid <= ret1;
      if (ret0) begin
        bus.resp0_q  <= div_q;
        bus.resp0_r  <= div_r;
        bus.resp0_dz <= tail.dz;
      end
      if (ret1) begin
        bus.resp1_q  <= div_q;
        bus.resp1_r  <= div_r;
        bus.resp1_dz <= tail.dz;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt0 <= '0;
      out_cnt1 <= '0;
    end else begin
      case ({grant0, ret0})
        2'b10:   out_cnt0 <= out_cnt0 + 4'd1;
        2'b01:   out_cnt0 <= out_cnt0 - 4'd1;
        default: out_cnt0 <= out_cnt0;
      endcase
      case ({grant1, ret1})
        2'b10:   out_cnt1 <= out_cnt1 + 4'd1;
        2'b01:   out_cnt1 <= out_cnt1 - 4'd1;
        default: out_cnt1 <= out_cnt1;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arb.sv
module tb_div_arb;
  localparam int unsigned DIV_LAT = 7;
  localparam int unsigned MAX_OUT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        div_in_valid;
  logic [7:0]  div_a;
  logic [4:0]  div_b;
  logic [7:0]  div_q;
  logic [4:0]  div_r;
  logic        div_out_valid;
  logic [50:0] number;

  div_arb_if bus ();

  div_arb #(.DIV_LAT(DIV_LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .div_in_valid(div_in_valid), .div_a(div_a), .div_b(div_b),
    .div_q(div_q), .div_r(div_r), .div_out_valid(div_out_valid),
    .number(number)
  );

  always #5 clk = ~clk;

  // Divider results as the bench defines them (divide by zero: q all ones, r = a[4:0]).
  function automatic logic [7:0] ref_q(input logic [7:0] a, input logic [4:0] b);
    return (b == 0) ? 8'hFF : a / {3'b0, b};
  endfunction
  function automatic logic [4:0] ref_r(input logic [7:0] a, input logic [4:0] b);
    logic [7:0] m;
    m = (b == 0) ? a : a % {3'b0, b};
    return m[4:0];
  endfunction

  // Shared divider: DIV_LAT-stage pipeline sampling the registered operands.
  logic [12:0] dres [DIV_LAT];
  logic        dvld [DIV_LAT];
  always @(posedge clk) begin
    dres[0] <= {ref_q(div_a, div_b), ref_r(div_a, div_b)};
    dvld[0] <= div_in_valid;
    for (int i = 1; i < DIV_LAT; i++) begin
      dres[i] <= dres[i-1];
      dvld[i] <= dvld[i-1];
    end
  end
  assign div_q         = dres[DIV_LAT-1][12:5];
  assign div_r         = dres[DIV_LAT-1][4:0];
  assign div_out_valid = dvld[DIV_LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: outstanding operations as a queue with due cycles.
  typedef struct {
    bit         id;
    logic [7:0] a;
    logic [4:0] b;
    int         due;
  } op_t;

  op_t        pend[$];
  int         cyc = 0;
  int         m_cnt [2];
  bit         m_ptr;
  logic [7:0] m_q  [2];
  logic [4:0] m_r  [2];
  logic       m_dz [2];
  logic [7:0] m_da;
  logic [4:0] m_db;

  task automatic model_clear();
    pend.delete();
    m_ptr = 0;
    m_da  = '0;
    m_db  = '0;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      m_q[i]   = '0;
      m_r[i]   = '0;
      m_dz[i]  = 1'b0;
    end
  endtask

  task automatic drive(input bit v0, input logic [7:0] a0, input logic [4:0] b0,
                       input bit v1, input logic [7:0] a1, input logic [4:0] b1);
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
  endtask

  task automatic idle();
    drive(0, '0, '0, 0, '0, '0);
  endtask

  // One clock cycle: check grants at the negedge, advance the model at the
  // posedge, check registered outputs 1 time unit later.
  task automatic cycle();
    bit  g0, g1, e0, e1, r0, r1;
    op_t o;
    g0 = 0; g1 = 0; r0 = 0; r1 = 0;
    @(negedge clk);
    if (rst_n) begin
      e0 = bus.req0_valid && (m_cnt[0] < int'(MAX_OUT));
      e1 = bus.req1_valid && (m_cnt[1] < int'(MAX_OUT));
      if (e0 && e1) begin
        g0 = (m_ptr == 0);
        g1 = (m_ptr == 1);
      end else begin
        g0 = e0;
        g1 = e1;
      end
    end
    check("ready0", {31'b0, bus.req0_ready}, {31'b0, g0});
    check("ready1", {31'b0, bus.req1_ready}, {31'b0, g1});
    check("out_cnt0", {28'b0, dut.out_cnt0}, m_cnt[0]);
    check("out_cnt1", {28'b0, dut.out_cnt1}, m_cnt[1]);
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      if (pend.size() > 0 && pend[0].due == cyc) begin
        o = pend.pop_front();
        if (o.id) r1 = 1; else r0 = 1;
        m_q[o.id]  = ref_q(o.a, o.b);
        m_r[o.id]  = ref_r(o.a, o.b);
        m_dz[o.id] = (o.b == 0);
        m_cnt[o.id]--;
      end
      if (g0) begin
        pend.push_back('{0, bus.req0_a, bus.req0_b, cyc + DIV_LAT + 1});
        m_cnt[0]++; m_ptr = 1; m_da = bus.req0_a; m_db = bus.req0_b;
      end
      if (g1) begin
        pend.push_back('{1, bus.req1_a, bus.req1_b, cyc + DIV_LAT + 1});
        m_cnt[1]++; m_ptr = 0; m_da = bus.req1_a; m_db = bus.req1_b;
      end
    end
    #1;
    check("div_in_valid", {31'b0, div_in_valid}, {31'b0, (g0 | g1)});
    check("div_a", {24'b0, div_a}, {24'b0, m_da});
    check("div_b", {27'b0, div_b}, {27'b0, m_db});
    check("resp0_valid", {31'b0, bus.resp0_valid}, {31'b0, r0});
    check("resp1_valid", {31'b0, bus.resp1_valid}, {31'b0, r1});
    check("resp0_q", {24'b0, bus.resp0_q}, {24'b0, m_q[0]});
    check("resp1_q", {24'b0, bus.resp1_q}, {24'b0, m_q[1]});
    check("resp0_r", {27'b0, bus.resp0_r}, {27'b0, m_r[0]});
    check("resp1_r", {27'b0, bus.resp1_r}, {27'b0, m_r[1]});
    check("resp0_dz", {31'b0, bus.resp0_dz}, {31'b0, m_dz[0]});
    check("resp1_dz", {31'b0, bus.resp1_dz}, {31'b0, m_dz[1]});
    check("number", number[31:0], 32'd0);
  endtask

  // Called right after cycle(): pulse reset between edges.
  task automatic pulse_reset(input int n);
    rst_n = 1'b0;
    model_clear();
    idle();
    repeat (n) cycle();
    rst_n = 1'b1;
  endtask

  function automatic logic [4:0] rand_b();
    logic [4:0] b;
    b = 5'($urandom);
    if ($urandom_range(0, 15) == 0) b = '0;
    return b;
  endfunction

  initial begin
    model_clear();
    idle();
    repeat (3) cycle();
    rst_n = 1'b1;

    // single op: 200 / 7 -> q=28 r=4 on requester 0
    drive(1, 8'd200, 5'd7, 0, '0, '0);
    cycle();
    idle();
    repeat (10) cycle();

    // contention: both valid every cycle
    for (int i = 0; i < 8; i++) begin
      drive(1, 8'($urandom), rand_b(), 1, 8'($urandom), rand_b());
      cycle();
    end
    idle();
    repeat (12) cycle();

    // credit limit: requester 0 continuously valid, requester 1 idle
    for (int i = 0; i < 24; i++) begin
      drive(1, 8'($urandom), rand_b(), 0, '0, '0);
      cycle();
    end
    idle();
    repeat (12) cycle();

    // zero divisor followed by a normal divisor on requester 1
    drive(0, '0, '0, 1, 8'd13, 5'd0);
    cycle();
    drive(0, '0, '0, 1, 8'd13, 5'd3);
    cycle();
    idle();
    repeat (10) cycle();

    // reset with three operations in flight, then a fresh op
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'($urandom), rand_b(), 1, 8'($urandom), rand_b());
      cycle();
    end
    pulse_reset(2);
    repeat (12) cycle();
    drive(1, 8'd99, 5'd10, 0, '0, '0);
    cycle();
    idle();
    repeat (10) cycle();

    // randomized traffic with varying load and occasional resets
    for (int blk = 0; blk < 6; blk++) begin
      int unsigned d0, d1;
      d0 = $urandom_range(10, 100);
      d1 = $urandom_range(10, 100);
      for (int i = 0; i < 400; i++) begin
        drive($urandom_range(1, 100) <= d0, 8'($urandom), rand_b(),
              $urandom_range(1, 100) <= d1, 8'($urandom), rand_b());
        cycle();
      end
      if (blk == 2) pulse_reset(1);
    end
    idle();
    repeat (12) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
